// File: rtl/pri_pkg.sv
// Shared definitions for the priority encode/decode pair.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: default output/index widths, the decoder FSM state type and
// a one-hot helper used to build the registered output word.
package pri_pkg;

    localparam int N_OUT_DEF = 8;
    localparam int W_IDX_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // 32-bit result; callers truncate to their own output width.
    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/pri_fifo.sv
// Small synchronous FIFO holding decoded-index requests.
// Latency: a pushed entry is visible at the head (empty=0) the cycle after the push.
// Backpressure: full when count==DEPTH; pushes while full and pops while empty are ignored.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   push, push_dat      write strobe and data
//   pop, pop_dat        read strobe and head data (head is valid whenever !empty)
//   full, empty, count  occupancy status; count is clog2(DEPTH)+1 bits
module pri_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        // DEPTH is a power of two, so the pointers wrap by natural overflow.
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/pri_dec.sv
// Buffered 3-to-8 decoder: queues indices and replays each as a HOLD-cycle one-hot pulse plus a zero gap.
// Latency: pulse is registered one cycle after the FIFO head is popped; HOLD high cycles then GAP and IDLE at zero.
// Backpressure: code_ready = FIFO not full; en=0 freezes the sequencer and masks y, input side keeps accepting.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   en             output enable / sequencer run
//   code, code_valid, code_ready   index input handshake
//   y, y_valid     registered one-hot output (masked by en)
//   busy           FIFO non-empty or sequencer not idle
//   err            one-cycle pulse after an out-of-range code is accepted
module pri_dec
    import pri_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int W_IDX = W_IDX_DEF,
    parameter int HOLD  = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W_IDX-1:0] code,
    input  logic             code_valid,
    output logic             code_ready,
    output logic [N_OUT-1:0] y,
    output logic             y_valid,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(HOLD) + 1;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [N_OUT-1:0]        y_q, y_d;
    logic                    y_valid_q, y_valid_d;
    logic                    err_q, err_d;

    logic                    fifo_push, fifo_pop;
    logic [W_IDX-1:0]        fifo_head;
    logic                    fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    accept, in_range;

    pri_fifo #(
        .DEPTH (DEPTH),
        .W     (W_IDX)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (code),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Ready depends on occupancy alone, never on code_valid.
    assign code_ready = !fifo_full;
    assign accept     = code_valid && code_ready;
    // Widened compare; constant-true when N_OUT == 2**W_IDX.
    assign in_range   = (32'(code) < 32'(N_OUT));
    // Out-of-range codes complete the handshake but are dropped here.
    assign fifo_push  = accept && in_range;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        fifo_pop  = 1'b0;
        err_d     = accept && !in_range;

        // en=0 freezes state and counter so a pulse resumes where it stopped.
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        y_d       = N_OUT'(onehot(32'(fifo_head)));
                        y_valid_d = 1'b1;
                        cnt_d     = CW'(HOLD - 1);
                        state_d   = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        y_d       = '0;
                        y_valid_d = 1'b0;
                        state_d   = GAP;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                GAP: begin
                    // Guarantees a zero cycle so repeated codes stay distinguishable.
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            err_q     <= err_d;
        end
    end

    assign y       = en ? y_q : '0;
    assign y_valid = en && y_valid_q;
    assign busy    = (fifo_count != '0) || (state_q != IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_pri_dec.sv
module tb_pri_dec;

    localparam int N     = 8;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst, en, code_valid, code_ready, y_valid, busy, err;
    logic [2:0] code;
    logic [7:0] y;

    logic       rst6, en6, vld6, ready6, yv6, busy6, err6;
    logic [2:0] code6;
    logic [5:0] y6;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pending codes, visible cycles left in the
    // current pulse, zero cycles left before the next pop may happen.
    int q[$];
    int rem = 0;
    int gap_left = 0;
    int cur = 0;
    bit m_err = 0;

    pri_dec #(.N_OUT(8), .W_IDX(3), .HOLD(HOLD), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .code(code), .code_valid(code_valid),
        .code_ready(code_ready), .y(y), .y_valid(y_valid), .busy(busy), .err(err)
    );

    pri_dec #(.N_OUT(6), .W_IDX(3), .HOLD(HOLD), .DEPTH(DEPTH)) u_dut6 (
        .clk(clk), .rst(rst6), .en(en6), .code(code6), .code_valid(vld6),
        .code_ready(ready6), .y(y6), .y_valid(yv6), .busy(busy6), .err(err6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model across one rising edge with the inputs sampled there.
    task automatic model_edge(input bit r, input bit e, input bit v, input int c);
        bit acc;
        if (r) begin
            q.delete();
            rem = 0;
            gap_left = 0;
            m_err = 0;
            return;
        end
        acc   = v && (q.size() != DEPTH);
        m_err = acc && (c >= N);
        if (e) begin
            if (rem > 0) begin
                rem--;
                // GAP cycle, then one IDLE cycle that performs the next pop.
                if (rem == 0) gap_left = 1;
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (q.size() > 0) begin
                cur = q.pop_front();
                rem = HOLD;
            end
        end
        if (acc && c < N) q.push_back(c);
    endtask

    task automatic step(input bit r, input bit e, input bit v, input logic [2:0] c);
        logic [7:0] ey;
        rst = r; en = e; code_valid = v; code = c;
        @(posedge clk);
        model_edge(r, e, v, int'(c));
        #1;
        ey = (e && rem > 0) ? 8'(1 << cur) : 8'h00;
        chk("y", 32'(y), 32'(ey));
        chk("y_valid", 32'(y_valid), 32'(e && rem > 0));
        chk("code_ready", 32'(code_ready), 32'(q.size() != DEPTH));
        chk("busy", 32'(busy), 32'(q.size() != 0 || rem > 0 || gap_left > 0));
        chk("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        rst6 = 1'b1; en6 = 1'b0; vld6 = 1'b0; code6 = '0;

        // Reset state.
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // Single code 3.
        step(0, 1, 1, 3);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

        // Back-to-back identical codes.
        step(0, 1, 1, 5);
        step(0, 1, 1, 5);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0);

        // Fill the FIFO with the sequencer stopped, then a stalled fifth code.
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 2);
        step(0, 0, 1, 7);
        step(0, 0, 1, 4);
        step(0, 0, 1, 4);
        for (int i = 0; i < 28; i++) step(0, 1, 0, 0);

        // en drop during the second hold cycle of code 6.
        step(0, 1, 1, 6);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

        // Reset mid-pulse with codes still queued.
        step(0, 1, 1, 1);
        step(0, 1, 1, 2);
        step(0, 1, 1, 3);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 79) == 0, ($urandom % 4) != 0,
                 ($urandom % 3) == 0, 3'($urandom));
        end
        step(0, 0, 0, 0);

        // Narrow instance: out-of-range code is accepted, flagged and dropped.
        @(posedge clk); #1;
        rst6 = 1'b0; en6 = 1'b1; code6 = 3'd7; vld6 = 1'b1;
        chk("ready6", 32'(ready6), 32'd1);
        @(posedge clk); #1;
        vld6 = 1'b0;
        chk("err6_pulse", 32'(err6), 32'd1);
        chk("busy6_oor", 32'(busy6), 32'd0);
        chk("yv6_oor", 32'(yv6), 32'd0);
        @(posedge clk); #1;
        chk("err6_clear", 32'(err6), 32'd0);
        chk("busy6_after", 32'(busy6), 32'd0);
        chk("yv6_after", 32'(yv6), 32'd0);
        code6 = 3'd5; vld6 = 1'b1;
        @(posedge clk); #1;
        vld6 = 1'b0;
        chk("busy6_queued", 32'(busy6), 32'd1);
        chk("err6_inrange", 32'(err6), 32'd0);
        @(posedge clk); #1;
        chk("y6_pulse", 32'(y6), 32'h20);
        chk("yv6_pulse", 32'(yv6), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
